// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage off-chip memory sequencer.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam logic BEAT_LO = 1'b0;
    localparam logic BEAT_HI = 1'b1;

    localparam int EXT_AW = 17;
    localparam int EXT_DW = 16;

endpackage

// File: rtl/mem_timeout.sv
// Per-beat wait counter; expired flags the last cycle a beat may still be acknowledged.
module mem_timeout #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_ctrl.sv
// Splits each 32-bit MEM access into two 16-bit req/ack beats (low half first),
// stalling the pipeline until done and aborting with MemErr if a beat times out.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TW      = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [15:0]       MemAddr,
    input  logic [31:0]       MemDataIn,
    output logic [31:0]       MemDataOut,
    output logic              Stall,
    output logic              MemErr,
    output logic              ExtReq,
    output logic              ExtWe,
    output logic [EXT_AW-1:0] ExtAddr,
    output logic [EXT_DW-1:0] ExtWData,
    input  logic [EXT_DW-1:0] ExtRData,
    input  logic              ExtAck
);

    state_t state, nextState;

    logic [15:0] addrQ;
    logic [31:0] wdataQ;
    logic        weQ;
    logic [15:0] rdataLo;
    logic [31:0] dataOutQ;
    logic        memErrQ;

    logic inBeat;
    logic expired;
    logic timeoutFire;
    logic accept;

    assign inBeat      = (state == LO) || (state == HI);
    assign timeoutFire = inBeat && !ExtAck && expired;
    assign accept      = (state == IDLE) && (MemRead || MemWrite);

    mem_timeout #(
        .TIMEOUT(TIMEOUT),
        .TW     (TW)
    ) uTimeout (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (!inBeat || ExtAck),
        .enable (inBeat && !ExtAck),
        .expired(expired)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        Stall     = 1'b0;
        ExtReq    = 1'b0;
        ExtWe     = 1'b0;
        ExtAddr   = '0;
        ExtWData  = '0;
        unique case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    Stall     = 1'b1;
                    nextState = LO;
                end
            end
            LO: begin
                Stall    = 1'b1;
                ExtReq   = 1'b1;
                ExtWe    = weQ;
                ExtAddr  = {addrQ, BEAT_LO};
                ExtWData = wdataQ[15:0];
                if (ExtAck) begin
                    nextState = HI;
                end else if (expired) begin
                    nextState = DONE;
                end
            end
            HI: begin
                Stall    = 1'b1;
                ExtReq   = 1'b1;
                ExtWe    = weQ;
                ExtAddr  = {addrQ, BEAT_HI};
                ExtWData = wdataQ[31:16];
                if (ExtAck || expired) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                // The pipeline advances now, so any request still present is not taken.
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Access latches carry no reset: they are always loaded before they are observed.
    always_ff @(posedge Clock) begin
        if (accept) begin
            addrQ  <= MemAddr;
            wdataQ <= MemDataIn;
            weQ    <= MemWrite;
        end
        if ((state == LO) && ExtAck && !weQ) begin
            rdataLo <= ExtRData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dataOutQ <= '0;
            memErrQ  <= 1'b0;
        end else begin
            memErrQ <= timeoutFire;
            if ((state == HI) && ExtAck && !weQ) begin
                dataOutQ <= {ExtRData, rdataLo};
            end else if (timeoutFire && !weQ) begin
                dataOutQ <= '0;
            end
        end
    end

    assign MemDataOut = dataOutQ;
    assign MemErr     = memErrQ;

endmodule
